// File: rtl/mux_arb_nway_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// Channel i data sits at in_data[i*WIDTH +: WIDTH].
interface mux_arb_nway_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_arb_nway.sv
// N-way W-bit mux with one output register and valid/ready on every side.
// Selection is round-robin (MODE 0), fixed priority (MODE 1) or explicit sel (MODE 2).
module mux_arb_nway_lane #(
    parameter int MODE = 0
) (
    input  logic valid,
    input  logic sel_hit,
    input  logic gnt_hit,
    input  logic en,
    output logic elig,
    output logic ready
);
    assign elig  = valid && (sel_hit || (MODE != 2));
    assign ready = en && gnt_hit;
endmodule

module mux_arb_nway #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int MODE     = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_arb_nway_if.slave  bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] lane_data;
    logic [CHANNELS-1:0]            sel_hit;
    logic [CHANNELS-1:0]            elig;
    logic [CHANNELS-1:0]            ready;
    logic [SEL_W-1:0]               ptr;
    logic [SEL_W-1:0]               base;
    logic [SEL_W-1:0]               gnt;
    logic [SEL_W-1:0]               idx_s;
    logic                           load;
    logic                           has_grant;
    logic                           en;
    int                             idx;

    logic [WIDTH-1:0]               out_data_q;
    logic [SEL_W-1:0]               out_chan_q;
    logic                           out_valid_q;

    assign lane_data = bus.in_data;
    assign load      = !out_valid_q || bus.out_ready;
    assign has_grant = |elig;
    assign en        = rst_n && load && has_grant;
    // Only round-robin rotates the scan start; the other modes scan from 0.
    assign base      = (MODE == 0) ? ptr : '0;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        assign sel_hit[i] = (bus.sel == SEL_W'(i));
        mux_arb_nway_lane #(.MODE(MODE)) u_lane (
            .valid   (bus.in_valid[i]),
            .sel_hit (sel_hit[i]),
            .gnt_hit (gnt == SEL_W'(i)),
            .en      (en),
            .elig    (elig[i]),
            .ready   (ready[i])
        );
    end

    // Scan base, base+1, ... modulo CHANNELS; walking downward lets the
    // nearest eligible index overwrite farther ones.
    always_comb begin
        gnt   = '0;
        idx   = 0;
        idx_s = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(base) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            idx_s = idx[SEL_W-1:0];
            if (elig[idx_s]) gnt = idx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr         <= '0;
        end else if (en) begin
            out_data_q  <= lane_data[gnt];
            out_chan_q  <= gnt;
            out_valid_q <= 1'b1;
            if (MODE == 0)
                ptr <= (gnt == SEL_W'(CHANNELS - 1)) ? '0 : gnt + SEL_W'(1);
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule
